colony_tally: RTL and testbench

- Downstream consumer of the ant array's per-ant `dropping_sugar` outputs.
- Counts sugar units delivered to each nest, tracks the leading colony, and exposes a rotating per-nest readout for the HEX displays.
- Runs on the location-scan clock alongside the environment and `env_cache`. Cleared by the simulation reset.

---
 rtl/colony_tally_pkg.sv | 12 +
 rtl/colony_tally_drop_arbiter.sv | 65 ++++++
 rtl/colony_tally.sv | 90 +++++++++
 tb/tb_colony_tally.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/colony_tally_pkg.sv
// Shared sizing constants and types for the colony sugar tally.
package colony_tally_pkg;

  localparam int unsigned ANT_num       = 8;
  localparam int unsigned NEST_num      = 4;
  localparam int unsigned NEST_num_bits = 2;
  localparam int unsigned COUNT_bits    = 16;
  localparam int unsigned ANT_idx_bits  = (ANT_num > 1) ? $clog2(ANT_num) : 1;

  typedef logic [NEST_num_bits-1:0] nest_id_t;

endpackage

// File: rtl/colony_tally_drop_arbiter.sv
// Edge-detects per-ant drops, queues them in a pending bitmap and grants the
// lowest-index pending ant each cycle; flags drops lost to an occupied slot.
module drop_arbiter
  import colony_tally_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_run,
  input  logic                    i_clr,
  input  logic [ANT_num-1:0]      i_ant_drop,
  output logic                    o_grant_valid,
  output logic [ANT_idx_bits-1:0] o_grant_idx,
  output logic                    o_busy,
  output logic                    o_lost_drop
);

  logic [ANT_num-1:0]      r_pending;
  logic [ANT_num-1:0]      r_prev_drop;
  logic                    r_lost;
  logic [ANT_num-1:0]      w_capture;
  logic [ANT_num-1:0]      w_grant_oh;
  logic                    w_found;
  logic [ANT_idx_bits-1:0] w_idx;

  always_comb begin
    w_capture = i_ant_drop & ~r_prev_drop & {ANT_num{i_run}};
  end

  always_comb begin
    w_found    = 1'b0;
    w_idx      = '0;
    w_grant_oh = '0;
    for (int unsigned i = 0; i < ANT_num; i++) begin
      if (r_pending[i] && !w_found) begin
        w_found       = 1'b1;
        w_idx         = ANT_idx_bits'(i);
        w_grant_oh[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pending   <= '0;
      r_prev_drop <= '0;
      r_lost      <= 1'b0;
    end else begin
      r_prev_drop <= i_ant_drop;
      if (i_clr) begin
        r_pending <= '0;
        r_lost    <= 1'b0;
      end else begin
        // A capture on the ant being granted re-arms it rather than being lost.
        r_pending <= (r_pending & ~w_grant_oh) | w_capture;
        if (|(w_capture & r_pending & ~w_grant_oh)) r_lost <= 1'b1;
      end
    end
  end

  assign o_grant_valid = w_found;
  assign o_grant_idx   = w_idx;
  assign o_busy        = |r_pending;
  assign o_lost_drop   = r_lost;

endmodule

// File: rtl/colony_tally.sv
// Per-nest sugar delivery counters with saturating total, leader tracking and
// a rotating registered readout for the HEX displays.
module colony_tally
  import colony_tally_pkg::*;
(
  input  logic                           newLocClock,
  input  logic                           RESET_SIM,
  input  logic                           RUN,
  input  logic                           clear_counts,
  input  logic [ANT_num-1:0]             ant_drop,
  input  logic [ANT_num*NEST_num_bits-1:0] ant_nest,
  input  logic                           disp_tick,
  output logic [NEST_num*COUNT_bits-1:0] nest_count,
  output logic [COUNT_bits-1:0]          total_count,
  output nest_id_t                       leader_nest,
  output nest_id_t                       disp_nest,
  output logic [COUNT_bits-1:0]          disp_count,
  output logic                           busy,
  output logic                           lost_drop
);

  logic [COUNT_bits-1:0]   r_count [NEST_num];
  logic [COUNT_bits-1:0]   r_total;
  nest_id_t                r_leader;
  nest_id_t                r_disp_nest;
  logic [COUNT_bits-1:0]   r_disp_count;

  logic                    w_grant_valid;
  logic [ANT_idx_bits-1:0] w_grant_idx;
  nest_id_t                w_grant_nest;
  logic [COUNT_bits-1:0]   w_sel_count;
  logic [COUNT_bits-1:0]   w_next_count;

  drop_arbiter u_arb (
    .i_clk        (newLocClock),
    .i_rst        (RESET_SIM),
    .i_run        (RUN),
    .i_clr        (clear_counts),
    .i_ant_drop   (ant_drop),
    .o_grant_valid(w_grant_valid),
    .o_grant_idx  (w_grant_idx),
    .o_busy       (busy),
    .o_lost_drop  (lost_drop)
  );

  always_comb begin
    w_grant_nest = ant_nest[w_grant_idx*NEST_num_bits +: NEST_num_bits];
    w_sel_count  = r_count[w_grant_nest];
    w_next_count = (w_sel_count == '1) ? w_sel_count : w_sel_count + 1'b1;
  end

  always_ff @(posedge newLocClock) begin
    if (RESET_SIM) begin
      for (int unsigned n = 0; n < NEST_num; n++) r_count[n] <= '0;
      r_total      <= '0;
      r_leader     <= '0;
      r_disp_nest  <= '0;
      r_disp_count <= '0;
    end else begin
      if (disp_tick)
        r_disp_nest <= (r_disp_nest == nest_id_t'(NEST_num-1)) ? '0 : r_disp_nest + 1'b1;
      if (clear_counts) begin
        for (int unsigned n = 0; n < NEST_num; n++) r_count[n] <= '0;
        r_total      <= '0;
        r_leader     <= '0;
        r_disp_count <= '0;
      end else begin
        r_disp_count <= r_count[r_disp_nest];
        if (w_grant_valid) begin
          r_count[w_grant_nest] <= w_next_count;
          if (r_total != '1) r_total <= r_total + 1'b1;
          // Strictly-greater keeps the incumbent on ties.
          if (w_next_count > r_count[r_leader]) r_leader <= w_grant_nest;
        end
      end
    end
  end

  always_comb begin
    nest_count = '0;
    for (int unsigned n = 0; n < NEST_num; n++)
      nest_count[n*COUNT_bits +: COUNT_bits] = r_count[n];
  end

  assign total_count = r_total;
  assign leader_nest = r_leader;
  assign disp_nest   = r_disp_nest;
  assign disp_count  = r_disp_count;

endmodule

// File: tb/tb_colony_tally.sv
// Randomized and directed bench for colony_tally against a behavioural model.
module tb_colony_tally;
  import colony_tally_pkg::*;

  localparam int CMAX = (1 << COUNT_bits) - 1;

  logic                             clk = 1'b0;
  logic                             rst, run, clr, tick;
  logic [ANT_num-1:0]               drop;
  logic [ANT_num*NEST_num_bits-1:0] nest_flat;
  int                               nest_of [ANT_num];

  logic [NEST_num*COUNT_bits-1:0]   nest_count;
  logic [COUNT_bits-1:0]            total_count, disp_count;
  nest_id_t                         leader_nest, disp_nest;
  logic                             busy, lost_drop;

  int n_checks = 0;
  int n_fail   = 0;
  bit do_chk   = 1'b1;

  // behavioural model state
  int m_cnt [NEST_num];
  int m_tot, m_lead, m_dn, m_dc;
  bit m_pend [ANT_num];
  bit m_prev [ANT_num];
  bit m_lost;

  int exp_dn [4] = '{1, 2, 3, 0};
  int exp_dc [4] = '{9, 0, 2, 5};

  colony_tally dut (
    .newLocClock (clk),
    .RESET_SIM   (rst),
    .RUN         (run),
    .clear_counts(clr),
    .ant_drop    (drop),
    .ant_nest    (nest_flat),
    .disp_tick   (tick),
    .nest_count  (nest_count),
    .total_count (total_count),
    .leader_nest (leader_nest),
    .disp_nest   (disp_nest),
    .disp_count  (disp_count),
    .busy        (busy),
    .lost_drop   (lost_drop)
  );

  always #5 clk = ~clk;

  always_comb begin
    nest_flat = '0;
    for (int i = 0; i < ANT_num; i++)
      nest_flat[i*NEST_num_bits +: NEST_num_bits] = NEST_num_bits'(nest_of[i]);
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int dut_cnt(input int n);
    return int'(nest_count[n*COUNT_bits +: COUNT_bits]);
  endfunction

  task automatic model_update();
    int g, nn, nc, new_dc;
    bit rise [ANT_num];
    if (rst) begin
      foreach (m_cnt[n]) m_cnt[n] = 0;
      foreach (m_pend[i]) begin m_pend[i] = 0; m_prev[i] = 0; end
      m_tot = 0; m_lead = 0; m_dn = 0; m_dc = 0; m_lost = 0;
      return;
    end
    g = -1;
    for (int i = 0; i < ANT_num; i++) if (m_pend[i] && g < 0) g = i;
    new_dc = m_cnt[m_dn];
    if (tick) m_dn = (m_dn + 1) % NEST_num;
    for (int i = 0; i < ANT_num; i++) begin
      rise[i]   = drop[i] && !m_prev[i];
      m_prev[i] = drop[i];
    end
    if (clr) begin
      foreach (m_cnt[n]) m_cnt[n] = 0;
      foreach (m_pend[i]) m_pend[i] = 0;
      m_tot = 0; m_lead = 0; m_dc = 0; m_lost = 0;
      return;
    end
    m_dc = new_dc;
    if (g >= 0) m_pend[g] = 0;
    for (int i = 0; i < ANT_num; i++) begin
      if (run && rise[i]) begin
        if (m_pend[i]) m_lost = 1;
        m_pend[i] = 1;
      end
    end
    if (g >= 0) begin
      nn = nest_of[g];
      nc = (m_cnt[nn] < CMAX) ? m_cnt[nn] + 1 : CMAX;
      if (nc > m_cnt[m_lead]) m_lead = nn;
      m_cnt[nn] = nc;
      if (m_tot < CMAX) m_tot++;
    end
  endtask

  task automatic check_all();
    bit any;
    any = 0;
    foreach (m_pend[i]) any |= m_pend[i];
    for (int n = 0; n < NEST_num; n++) check($sformatf("cnt%0d", n), dut_cnt(n), m_cnt[n]);
    check("total", total_count, m_tot);
    check("leader", leader_nest, m_lead);
    check("busy", busy, any);
    check("lost", lost_drop, m_lost);
    check("dnest", disp_nest, m_dn);
    check("dcount", disp_count, m_dc);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    if (do_chk) check_all();
  endtask

  task automatic deliver(input int a, input int n);
    nest_of[a] = n;
    drop[a] = 1'b1;
    step();
    drop[a] = 1'b0;
    step();
  endtask

  initial begin
    rst = 1; run = 0; clr = 0; tick = 0; drop = '0;
    foreach (nest_of[i]) nest_of[i] = 0;
    repeat (3) step();
    rst = 0;
    step();
    check("rst_total", total_count, 0);
    check("rst_leader", leader_nest, 0);
    check("rst_dnest", disp_nest, 0);
    check("rst_busy", busy, 0);

    // single delivery: ant 5 -> nest 2
    run = 1;
    foreach (nest_of[i]) nest_of[i] = 3 - (i % 4);
    drop = 8'b0010_0000; step();
    drop = '0; step();
    check("t1_cnt2", dut_cnt(2), 1);
    check("t1_total", total_count, 1);
    check("t1_leader", leader_nest, 2);

    // three simultaneous rises, lowest index first
    clr = 1; step(); clr = 0;
    nest_of[0] = 0; nest_of[4] = 3; nest_of[7] = 3;
    drop = 8'b1001_0001; step();
    check("t2_busyN", busy, 1);
    drop = '0; step();
    check("t2_cnt0", dut_cnt(0), 1);
    check("t2_lead1", leader_nest, 0);
    step();
    check("t2_cnt3a", dut_cnt(3), 1);
    check("t2_busy2", busy, 1);
    step();
    check("t2_cnt3b", dut_cnt(3), 2);
    check("t2_lead3", leader_nest, 3);
    check("t2_total", total_count, 3);
    check("t2_idle", busy, 0);

    // RUN=0 blocks capture; clear overrides a capture
    run = 0; drop = 8'b0000_0100; step();
    drop = '0; step(); step();
    check("t3_total", total_count, 3);
    run = 1; clr = 1; drop = 8'b0100_0000; step();
    clr = 0; drop = '0; step();
    check("t3_clr_total", total_count, 0);
    check("t3_clr_busy", busy, 0);

    // display rotation with counts {5,9,0,2}
    repeat (5) deliver(0, 0);
    repeat (9) deliver(1, 1);
    repeat (2) deliver(3, 3);
    step();
    for (int k = 0; k < 4; k++) begin
      tick = 1; step(); tick = 0;
      check("disp_nest", disp_nest, exp_dn[k]);
      step();
      check("disp_count", disp_count, exp_dc[k]);
    end

    // saturation on nest 1
    clr = 1; step(); clr = 0;
    foreach (nest_of[i]) nest_of[i] = 1;
    do_chk = 0;
    for (int c = 0; c < CMAX - 1; c++) begin
      drop = ANT_num'(1) << (c % ANT_num);
      step();
    end
    drop = '0; step(); step();
    do_chk = 1;
    check("sat_pre", dut_cnt(1), CMAX - 1);
    check_all();
    deliver(3, 1);
    check("sat_1", dut_cnt(1), CMAX);
    check("sat_tot1", total_count, CMAX);
    deliver(5, 1);
    check("sat_2", dut_cnt(1), CMAX);
    check("sat_tot2", total_count, CMAX);
    check("sat_busy", busy, 0);

    // randomized traffic
    clr = 1; step(); clr = 0;
    for (int c = 0; c < 1500; c++) begin
      rst  = ($urandom % 300) == 0;
      clr  = ($urandom % 64) == 0;
      run  = ($urandom % 8) != 0;
      tick = ($urandom % 4) == 0;
      drop = ANT_num'($urandom & $urandom & $urandom);
      if (($urandom % 16) == 0) nest_of[$urandom % ANT_num] = int'($urandom % NEST_num);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
